// File: rtl/uart_burst_rx.sv
// ---------------------------------------------------------------------------
// uart_burst_rx
//   8N1 UART receiver that collects a burst of back-to-back serial bytes
//   (LSB first). The burst length is latched from bytes_to_rx when the first
//   start bit of a burst is accepted; bytes_to_rx = N means N+1 bytes.
//
// Ports
//   clock          : system clock, rising edge
//   reset          : synchronous, active-high reset
//   bytes_to_rx    : burst length minus one
//   serial_data_in : serial line, idles high (synchronized internally)
//   rx_data_valid  : one-cycle strobe, rx_data_byte updated this cycle
//   rx_data_byte   : last correctly framed byte, held between strobes
//   rx_busy        : high whenever the receiver is not idle
//   rx_frame_error : one-cycle strobe when a stop bit is sampled low
//   rx_burst_done  : one-cycle strobe alongside the last byte of a burst
// ---------------------------------------------------------------------------
module uart_burst_rx #(
  parameter int CLKS_PER_BIT = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] bytes_to_rx,
  input  logic       serial_data_in,
  output logic       rx_data_valid,
  output logic [7:0] rx_data_byte,
  output logic       rx_busy,
  output logic       rx_frame_error,
  output logic       rx_burst_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF  = CLKS_PER_BIT / 2;

  // Terminal counts: mid-bit of the start bit, and one full bit period.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BIT  = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_in;

  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [9:0]       byte_cnt;
  logic [9:0]       burst_len;
  logic [7:0]       shift_reg;
  logic             err_wait;   // line must go high again after a bad frame

  logic tick_half, tick_bit, start_detect;

  // Decoded per-cycle actions from the output process.
  logic clk_clr, clk_inc, bit_clr, shift_en;
  logic latch_len, good_stop, bad_stop, err_clear;

  assign s_in         = sync_q[SYNC_STAGES-1];
  assign tick_half    = (clk_cnt == HALF_LAST);
  assign tick_bit     = (clk_cnt == BIT_LAST);
  assign start_detect = !err_wait && !s_in;
  assign rx_busy      = (state != IDLE);

  // Input synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clock) begin
    // NOTE: sequential state always uses <= so every flop samples the
    // pre-edge values and the chain shifts by exactly one stage per clock.
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= serial_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default for every output of a combinational block keeps
    // paths that do not assign it from inferring a latch.
    next_state = state;
    unique case (state)
      IDLE:      if (start_detect) next_state = START_BIT;
      START_BIT: if (tick_half)    next_state = s_in ? IDLE : DATA_BIT;
      DATA_BIT:  if (tick_bit && (bit_cnt == 3'd7)) next_state = STOP_BIT;
      STOP_BIT:  if (tick_bit)     next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output (action) decode.
  always_comb begin
    clk_clr   = 1'b0;
    clk_inc   = 1'b0;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    latch_len = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    err_clear = 1'b0;
    unique case (state)
      IDLE: begin
        // Counter is held at zero while idle, so it is clear on detect.
        clk_clr   = 1'b1;
        latch_len = start_detect && (byte_cnt == 10'd0);
        err_clear = err_wait && s_in;
      end
      START_BIT: begin
        if (tick_half) begin
          clk_clr = 1'b1;
          bit_clr = 1'b1;
        end else begin
          clk_inc = 1'b1;
        end
      end
      DATA_BIT: begin
        if (tick_bit) begin
          clk_clr  = 1'b1;
          shift_en = 1'b1;
        end else begin
          clk_inc = 1'b1;
        end
      end
      STOP_BIT: begin
        if (tick_bit) begin
          clk_clr   = 1'b1;
          good_stop = s_in;
          bad_stop  = !s_in;
        end else begin
          clk_inc = 1'b1;
        end
      end
      default: clk_clr = 1'b1;
    endcase
  end

  // Datapath and registered output strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_cnt        <= '0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      burst_len      <= '0;
      shift_reg      <= '0;
      err_wait       <= 1'b0;
      rx_data_valid  <= 1'b0;
      rx_data_byte   <= '0;
      rx_frame_error <= 1'b0;
      rx_burst_done  <= 1'b0;
    end else begin
      rx_data_valid  <= good_stop;
      rx_frame_error <= bad_stop;
      rx_burst_done  <= good_stop && (byte_cnt == burst_len);

      if (clk_clr)      clk_cnt <= '0;
      else if (clk_inc) clk_cnt <= clk_cnt + CNT_W'(1);

      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        // Shift right so the first data bit ends up in bit 0.
        shift_reg <= {s_in, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end

      if (latch_len) burst_len <= bytes_to_rx;

      if (good_stop) begin
        rx_data_byte <= shift_reg;
        byte_cnt     <= (byte_cnt == burst_len) ? 10'd0 : byte_cnt + 10'd1;
      end else if (bad_stop) begin
        byte_cnt <= '0;
      end

      if (bad_stop)       err_wait <= 1'b1;
      else if (err_clear) err_wait <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_burst_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_burst_rx
//   Self-checking bench for uart_burst_rx. Two instances: CLKS_PER_BIT=2 for
//   the directed table, corner sequences, random traffic and a 1024-byte
//   burst, and CLKS_PER_BIT=16 for the slow-rate sweep. Output strobes are
//   collected as events on the falling edge and compared in order against
//   expectations from the table or from a burst-level reference model.
// ---------------------------------------------------------------------------
module tb_uart_burst_rx;

  localparam int CPB_A = 2;
  localparam int CPB_B = 16;
  localparam int SYNC  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] bytes_a = 10'd0;
  logic [9:0] bytes_b = 10'd1;
  logic       serial_a = 1'b1;
  logic       serial_b = 1'b1;

  logic       valid_a, busy_a, ferr_a, done_a;
  logic [7:0] byte_a;
  logic       valid_b, busy_b, ferr_b, done_b;
  logic [7:0] byte_b;

  always #5 clock = ~clock;

  uart_burst_rx #(.CLKS_PER_BIT(CPB_A), .SYNC_STAGES(SYNC)) dut_a (
    .clock          (clock),
    .reset          (reset),
    .bytes_to_rx    (bytes_a),
    .serial_data_in (serial_a),
    .rx_data_valid  (valid_a),
    .rx_data_byte   (byte_a),
    .rx_busy        (busy_a),
    .rx_frame_error (ferr_a),
    .rx_burst_done  (done_a)
  );

  uart_burst_rx #(.CLKS_PER_BIT(CPB_B), .SYNC_STAGES(SYNC)) dut_b (
    .clock          (clock),
    .reset          (reset),
    .bytes_to_rx    (bytes_b),
    .serial_data_in (serial_b),
    .rx_data_valid  (valid_b),
    .rx_data_byte   (byte_b),
    .rx_busy        (busy_b),
    .rx_frame_error (ferr_b),
    .rx_burst_done  (done_b)
  );

  typedef struct packed {
    logic       valid;
    logic       err;
    logic [7:0] data;
    logic       done;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [9:0] len;
    int         gap;
    logic       exp_valid;
    logic       exp_err;
    logic [7:0] exp_byte;
    logic       exp_done;
  } vec_t;

  ev_t  got_a[$];
  ev_t  got_b[$];
  ev_t  exp_a[$];
  int   rd_a = 0;
  int   busy_cycles_a = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Burst-level reference model state.
  int         m_cnt  = 0;
  int         m_len  = 0;
  logic [7:0] m_last = 8'h00;

  // Event monitor: any strobe cycle becomes one event.
  always @(negedge clock) begin
    if (valid_a || ferr_a || done_a)
      got_a.push_back('{valid_a, ferr_a, byte_a, done_a});
    if (valid_b || ferr_b || done_b)
      got_b.push_back('{valid_b, ferr_b, byte_b, done_b});
    if (busy_a) busy_cycles_a++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic drive_bit(input int sel, input logic v, input int n);
    if (sel == 0) serial_a = v;
    else          serial_b = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic stop, input int gap);
    int cpb;
    cpb = (sel == 0) ? CPB_A : CPB_B;
    drive_bit(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], cpb);
    drive_bit(sel, stop, cpb);
    if (gap > 0) drive_bit(sel, 1'b1, gap);
  endtask

  // Reference model: a frame whose start bit is accepted with no burst in
  // progress begins a burst of bytes_to_rx+1 bytes; good frames count up to
  // the last byte, a bad frame aborts the burst and leaves the byte held.
  function automatic void model_frame(input logic [7:0] d, input logic stop);
    logic last;
    if (m_cnt == 0) m_len = int'(bytes_a);
    if (stop) begin
      last = (m_cnt == m_len);
      exp_a.push_back('{1'b1, 1'b0, d, last});
      m_last = d;
      m_cnt  = last ? 0 : m_cnt + 1;
    end else begin
      exp_a.push_back('{1'b0, 1'b1, m_last, 1'b0});
      m_cnt = 0;
    end
  endfunction

  // Compare newly collected events of instance A against expectations.
  task automatic compare_a(input string tag);
    int n_got;
    n_got = got_a.size() - rd_a;
    check({tag, " event count"}, n_got, exp_a.size());
    for (int i = 0; i < exp_a.size() && i < n_got; i++)
      check($sformatf("%s event %0d {valid,err,byte,done}", tag, i),
            32'(got_a[rd_a + i]), 32'(exp_a[i]));
    rd_a = got_a.size();
    exp_a.delete();
  endtask

  vec_t vt[8];
  ev_t  exp_b[2];

  initial begin
    logic [7:0] d;
    logic       stop;
    int         gap;
    int         busy0;

    //            data   stop  len    gap  valid err   byte   done
    vt[0] = '{8'h77, 1'b1, 10'd3, 0, 1'b1, 1'b0, 8'h77, 1'b0};
    vt[1] = '{8'hC9, 1'b1, 10'd3, 0, 1'b1, 1'b0, 8'hC9, 1'b0};
    vt[2] = '{8'hEB, 1'b1, 10'd3, 0, 1'b1, 1'b0, 8'hEB, 1'b0};
    vt[3] = '{8'h4D, 1'b1, 10'd3, 4, 1'b1, 1'b0, 8'h4D, 1'b1};
    vt[4] = '{8'h55, 1'b0, 10'd3, 4, 1'b0, 1'b1, 8'h4D, 1'b0};
    vt[5] = '{8'hA5, 1'b1, 10'd0, 4, 1'b1, 1'b0, 8'hA5, 1'b1};
    vt[6] = '{8'h01, 1'b1, 10'd0, 6, 1'b1, 1'b0, 8'h01, 1'b1};
    vt[7] = '{8'h80, 1'b1, 10'd0, 6, 1'b1, 1'b0, 8'h80, 1'b1};

    // Reset with the line high.
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("reset rx_data_valid",  valid_a, 0);
    check("reset rx_data_byte",   byte_a,  0);
    check("reset rx_busy",        busy_a,  0);
    check("reset rx_frame_error", ferr_a,  0);
    check("reset rx_burst_done",  done_a,  0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Directed table: 4-byte back-to-back burst, framing error, recovery,
    // single-byte bursts.
    for (int i = 0; i < 8; i++) begin
      bytes_a = vt[i].len;
      send_frame(0, vt[i].data, vt[i].stop, vt[i].gap);
    end
    repeat (40) @(negedge clock);
    for (int i = 0; i < 8; i++)
      if (vt[i].exp_valid || vt[i].exp_err)
        exp_a.push_back('{vt[i].exp_valid, vt[i].exp_err, vt[i].exp_byte, vt[i].exp_done});
    compare_a("table");
    check("byte held after table", byte_a, 8'h80);

    // Glitch: line low for a single cycle.
    busy0 = busy_cycles_a;
    serial_a = 1'b0;
    @(negedge clock);
    serial_a = 1'b1;
    repeat (12) @(negedge clock);
    check("glitch rx_busy seen", 32'(busy_cycles_a != busy0), 1);
    check("glitch rx_busy dropped", busy_a, 0);
    compare_a("glitch");

    // Reset in the middle of byte 2 of a burst.
    bytes_a = 10'd3;
    send_frame(0, 8'h11, 1'b1, 0);
    exp_a.push_back('{1'b1, 1'b0, 8'h11, 1'b0});
    d = 8'hC3;
    drive_bit(0, 1'b0, CPB_A);
    for (int i = 0; i < 3; i++) drive_bit(0, d[i], CPB_A);
    check("busy mid-frame", busy_a, 1);
    serial_a = 1'b1;
    reset    = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post-reset rx_busy", busy_a, 0);
    check("post-reset rx_data_byte", byte_a, 0);
    repeat (6) @(negedge clock);
    compare_a("reset mid-frame");
    send_frame(0, 8'h3C, 1'b1, 4);
    repeat (30) @(negedge clock);
    exp_a.push_back('{1'b1, 1'b0, 8'h3C, 1'b0});
    compare_a("after reset");

    // Random traffic against the reference model (burst 3 still open).
    m_cnt  = 1;
    m_len  = 3;
    m_last = 8'h3C;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) bytes_a = 10'($urandom_range(0, 3));
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      gap  = stop ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
      model_frame(d, stop);
      send_frame(0, d, stop, gap);
    end
    repeat (40) @(negedge clock);
    compare_a("random");

    // Maximum burst: 1024 bytes, length input changed after the first byte.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    m_cnt  = 0;
    m_last = 8'h00;
    bytes_a = 10'd1023;
    for (int i = 0; i < 1024; i++) begin
      d = 8'($urandom);
      model_frame(d, 1'b1);
      send_frame(0, d, 1'b1, 0);
      if (i == 0) bytes_a = 10'd0;
    end
    repeat (40) @(negedge clock);
    compare_a("burst1024");

    // Slow rate: CLKS_PER_BIT=16, two back-to-back frames, burst of two.
    send_frame(1, 8'hA5, 1'b1, 0);
    send_frame(1, 8'h5A, 1'b1, 0);
    repeat (200) @(negedge clock);
    exp_b[0] = '{1'b1, 1'b0, 8'hA5, 1'b0};
    exp_b[1] = '{1'b1, 1'b0, 8'h5A, 1'b1};
    check("cpb16 event count", got_b.size(), 2);
    for (int i = 0; i < 2 && i < got_b.size(); i++)
      check($sformatf("cpb16 event %0d {valid,err,byte,done}", i), 32'(got_b[i]), 32'(exp_b[i]));
    check("cpb16 rx_busy idle", busy_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_burst_rx.md
Name: uart_burst_rx

Overview:
- 8N1 UART receiver. Receives a burst of back-to-back serial bytes, LSB first. Burst length is set by a software-programmed count.
- Each received byte is delivered as an 8-bit word with a one-cycle valid strobe. Completion of the burst is flagged by a pulse.
- Sits between the board serial input pin and the byte-consuming logic (FIFO/register file), in the single system clock domain.

Parameters:
- CLKS_PER_BIT, 2, clock cycles per serial bit period (minimum 2).
- SYNC_STAGES, 2, number of input synchronizer flops on serial_data_in (minimum 1).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- bytes_to_rx  in  10  burst length minus one: N means N+1 bytes. Latched when the first start bit of a burst is accepted.
- serial_data_in  in  1  serial line; idles high.
- rx_data_valid  out  1  one-cycle pulse; rx_data_byte is new this cycle.
- rx_data_byte  out  8  last correctly framed byte; held between pulses.
- rx_busy  out  1  high in any state except IDLE.
- rx_frame_error  out  1  one-cycle pulse when a stop bit is sampled low.
- rx_burst_done  out  1  one-cycle pulse, coincident with the rx_data_valid of the last byte of the burst.

Behaviour:
- Interface: one clock, `clock`; reset `reset` is synchronous and active-high.
- Reset values:
  - Outputs all 0.
  - State IDLE; clock, bit and byte counters 0; shift register 0.
  - Synchronizer flops 1.
- Reset asserted mid-frame or mid-burst:
  - Partial byte and burst progress are discarded.
  - No output pulses are generated.
- All sampling uses the synchronized input (s_in). s_in lags the pin by SYNC_STAGES cycles; this is a fixed offset with no other effect.
- HALF = CLKS_PER_BIT/2 (integer division).
- State machine (2-bit):
  - IDLE:
    - Wait for s_in==0.
    - On detect: clear the clock counter, go to START_BIT.
    - If the byte counter is 0, latch bytes_to_rx into the burst-length register.
  - START_BIT:
    - Count HALF cycles to reach mid-bit, then sample s_in.
    - Sample 0: clear the clock counter and bit counter, go to DATA_BIT.
    - Sample 1: glitch. Return to IDLE with byte counter unchanged and no pulses.
  - DATA_BIT:
    - Every CLKS_PER_BIT cycles, sample s_in into the shift register, LSB first (first data bit becomes bit 0).
    - The 3-bit bit counter increments per sample.
    - After the 8th sample (counter wraps 7→0), go to STOP_BIT.
  - STOP_BIT: after CLKS_PER_BIT cycles, sample s_in.
    - Sample 1, good frame:
      - Register rx_data_byte from the shift register; pulse rx_data_valid.
      - If the byte counter equals the latched length: pulse rx_burst_done and clear the byte counter. Otherwise increment it.
      - Go to IDLE in the next cycle.
    - Sample 0, bad frame:
      - Pulse rx_frame_error; rx_data_byte unchanged; no valid pulse.
      - Clear the byte counter (burst aborted).
      - Go to IDLE. The line must return high before a new start bit is accepted, so IDLE requires s_in==1 after an error before it re-arms.
- Back-to-back frames: IDLE is re-entered right after the stop-bit mid-sample, so a start bit that immediately follows the stop bit (no idle gap) is caught. Resync happens on every start edge.
- Burst length:
  - bytes_to_rx=0 gives single-byte bursts. bytes_to_rx=1023 gives 1024 bytes.
  - Changing bytes_to_rx mid-burst has no effect until the next burst.
- Idle gaps between bytes of a burst are allowed; the burst does not time out.

Test Plan:
- Reset with line high for 4 cycles, then burst, CLKS_PER_BIT=2, bytes_to_rx=3, line held high 4 cycles then 4 back-to-back frames (no idle gaps) with LSB-first bits 11101110, 10010011, 11010111, 10110010:
  - Four rx_data_valid pulses with rx_data_byte = 0x77, 0xC9, 0xEB, 0x4D.
  - rx_burst_done pulses only with 0x4D.
  - rx_frame_error never asserts.
- Glitch rejection: line low for 1 cycle only, then high → no valid pulse, state returns to IDLE, rx_busy drops.
- Framing error: frame 0x55 with stop bit 0 → rx_frame_error pulse, rx_data_byte keeps its previous value, and the next good frame 0xA5 is received normally after the line returns high.
- Single-byte bursts: bytes_to_rx=0, two frames 0x01 and 0x80 separated by idle → each yields rx_data_valid together with rx_burst_done.
- Reset mid-frame: assert reset during DATA_BIT of byte 2 → no pulses, rx_busy=0, rx_data_byte=0x00; the next full frame 0x3C is received correctly.
- Parameter sweep, CLKS_PER_BIT=16: frame 0xA5 plus a back-to-back frame 0x5A → both bytes correct with mid-bit sampling.
